radio_txrx_sequencer: RTL and testbench



---
 rtl/radio_seq_pkg.sv | 25 ++
 rtl/radio_seq_gain_ramp.sv | 67 ++++++
 rtl/radio_txrx_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_radio_txrx_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/radio_seq_pkg.sv
// Shared definitions for the radio Tx/Rx sequencer: state codes, antenna
// switch encodings and default bus widths.
package radio_seq_pkg;

  localparam int DLY_W_DEF  = 16;
  localparam int GAIN_W_DEF = 6;

  localparam logic [1:0] ANTSW_OFF = 2'b00;
  localparam logic [1:0] ANTSW_RX  = 2'b01;
  localparam logic [1:0] ANTSW_TX  = 2'b10;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE      = 4'd0;
  localparam state_t ST_TX_EN     = 4'd1;
  localparam state_t ST_TX_PA     = 4'd2;
  localparam state_t ST_TX_RAMPUP = 4'd3;
  localparam state_t ST_TX_START  = 4'd4;
  localparam state_t ST_TX_ACTIVE = 4'd5;
  localparam state_t ST_TX_RAMPDN = 4'd6;
  localparam state_t ST_TX_PAOFF  = 4'd7;
  localparam state_t ST_RX_EN     = 4'd8;
  localparam state_t ST_RX_ACTIVE = 4'd9;

endpackage

// File: rtl/radio_seq_gain_ramp.sv
// Tx gain register with saturating up/down ramp, one step per programmable period.
// at_target/at_zero rise together with the final gain value and hold until the next start.
module radio_seq_gain_ramp #(
  parameter int GAIN_W = 6,
  parameter int DLY_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_up,
  input  logic              start_dn,
  input  logic [GAIN_W-1:0] target,
  input  logic [GAIN_W-1:0] step,
  input  logic [DLY_W-1:0]  dly_step,
  output logic [GAIN_W-1:0] gain,
  output logic              at_target,
  output logic              at_zero
);

  logic              run_up, run_dn;
  logic [DLY_W-1:0]  cnt, period;
  logic [GAIN_W-1:0] step_eff, up_val, dn_val;
  logic [GAIN_W:0]   sum;

  assign period   = (dly_step == '0) ? DLY_W'(1) : dly_step;
  assign step_eff = (step == '0) ? GAIN_W'(1) : step;
  // One extra bit so gain+step can never wrap below the target.
  assign sum      = {1'b0, gain} + {1'b0, step_eff};
  assign up_val   = (sum >= {1'b0, target}) ? target : sum[GAIN_W-1:0];
  assign dn_val   = (gain > step_eff) ? (gain - step_eff) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gain      <= '0;
      cnt       <= '0;
      run_up    <= 1'b0;
      run_dn    <= 1'b0;
      at_target <= 1'b0;
      at_zero   <= 1'b0;
    end else if (start_up || start_dn) begin
      run_up    <= start_up;
      run_dn    <= start_dn & ~start_up;
      cnt       <= period;
      at_target <= 1'b0;
      at_zero   <= 1'b0;
    end else if (run_up || run_dn) begin
      if (cnt == DLY_W'(1)) begin
        cnt <= period;
        if (run_up) begin
          gain <= up_val;
          if (up_val == target) begin
            at_target <= 1'b1;
            run_up    <= 1'b0;
          end
        end else begin
          gain <= dn_val;
          if (dn_val == '0) begin
            at_zero <= 1'b1;
            run_dn  <= 1'b0;
          end
        end
      end else begin
        cnt <= cnt - DLY_W'(1);
      end
    end
  end

endmodule

// File: rtl/radio_txrx_sequencer.sv
// Radio Tx/Rx control-line sequencer with settling delays and Tx gain ramping.
// Optional Tx watchdog enabled by defining RADIO_SEQ_TX_TIMEOUT_EN.
module radio_txrx_sequencer
  import radio_seq_pkg::*;
#(
  parameter int DLY_W  = DLY_W_DEF,
  parameter int GAIN_W = GAIN_W_DEF
) (
  input  logic              converter_clock_in,
  input  logic              sys_rst_n,
  input  logic              tx_req,
  input  logic              rx_req,
  input  logic              band_5ghz,
  input  logic [GAIN_W-1:0] tx_gain_target,
  input  logic [GAIN_W-1:0] gain_step,
  input  logic [DLY_W-1:0]  dly_txen_to_pa,
  input  logic [DLY_W-1:0]  dly_pa_to_ramp,
  input  logic [DLY_W-1:0]  dly_gain_step,
  input  logic [DLY_W-1:0]  dly_rxhp,
`ifdef RADIO_SEQ_TX_TIMEOUT_EN
  input  logic [31:0]       tx_timeout_cycles,
  output logic              tx_timeout,
`endif
  output logic              ctl_TxEn,
  output logic              ctl_RxEn,
  output logic              ctl_RxHP,
  output logic              ctl_24PA,
  output logic              ctl_5PA,
  output logic [1:0]        ctl_ANTSW,
  output logic [GAIN_W-1:0] ctl_Tx_gain,
  output logic              ctl_TxStart,
  output logic              busy,
  output logic              tx_active,
  output logic              rx_active
);

  function automatic logic [DLY_W-1:0] at_least_1(input logic [DLY_W-1:0] d);
    return (d == '0) ? DLY_W'(1) : d;
  endfunction

  state_t            state, nxt;
  logic [DLY_W-1:0]  cnt, cnt_val;
  logic              cnt_load, cnt_last;
  logic              band_q;
  logic [GAIN_W-1:0] tgt_q;
  logic              start_up, start_dn, at_target, at_zero;
  logic              tx_go, to_fire;
  logic              nxt_tx_en, nxt_pa, nxt_rx_en;

  assign cnt_last = (cnt == DLY_W'(1));

`ifdef RADIO_SEQ_TX_TIMEOUT_EN
  logic [31:0] to_cnt;
  logic        tx_lock;

  assign to_fire = (state == ST_TX_ACTIVE) && tx_req && (tx_timeout_cycles != 32'd0) &&
                   (to_cnt == tx_timeout_cycles - 32'd1);
  assign tx_go   = tx_req && !tx_lock;

  // tx_lock holds off a new Tx after a timeout until tx_req has been seen low.
  always_ff @(posedge converter_clock_in) begin
    if (!sys_rst_n) begin
      to_cnt     <= '0;
      tx_timeout <= 1'b0;
      tx_lock    <= 1'b0;
    end else begin
      to_cnt <= (state == ST_TX_ACTIVE && nxt == ST_TX_ACTIVE) ? to_cnt + 32'd1 : 32'd0;
      if (to_fire) begin
        tx_timeout <= 1'b1;
        tx_lock    <= 1'b1;
      end else begin
        if (state == ST_IDLE && nxt == ST_TX_EN) tx_timeout <= 1'b0;
        if (!tx_req) tx_lock <= 1'b0;
      end
    end
  end
`else
  assign to_fire = 1'b0;
  assign tx_go   = tx_req;
`endif

  always_comb begin
    nxt      = state;
    cnt_load = 1'b0;
    cnt_val  = at_least_1(dly_txen_to_pa);
    start_up = 1'b0;
    start_dn = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tx_go) begin
          nxt      = ST_TX_EN;
          cnt_load = 1'b1;
        end else if (rx_req) begin
          nxt      = ST_RX_EN;
          cnt_load = 1'b1;
          cnt_val  = at_least_1(dly_rxhp);
        end
      end
      ST_TX_EN: if (cnt_last) begin
        nxt      = ST_TX_PA;
        cnt_load = 1'b1;
        cnt_val  = at_least_1(dly_pa_to_ramp);
      end
      ST_TX_PA: if (cnt_last) begin
        nxt      = ST_TX_RAMPUP;
        start_up = 1'b1;
      end
      ST_TX_RAMPUP: if (at_target) nxt = ST_TX_START;
      ST_TX_START:  nxt = ST_TX_ACTIVE;
      ST_TX_ACTIVE: if (!tx_req || to_fire) begin
        nxt      = ST_TX_RAMPDN;
        start_dn = 1'b1;
      end
      ST_TX_RAMPDN: if (at_zero) begin
        nxt      = ST_TX_PAOFF;
        cnt_load = 1'b1;
      end
      ST_TX_PAOFF:  if (cnt_last) nxt = ST_IDLE;
      ST_RX_EN:     if (cnt_last) nxt = ST_RX_ACTIVE;
      ST_RX_ACTIVE: if (!rx_req) nxt = ST_IDLE;
      default:      nxt = ST_IDLE;
    endcase
  end

  assign nxt_tx_en = (nxt inside {ST_TX_EN, ST_TX_PA, ST_TX_RAMPUP, ST_TX_START,
                                  ST_TX_ACTIVE, ST_TX_RAMPDN, ST_TX_PAOFF});
  assign nxt_pa    = (nxt inside {ST_TX_PA, ST_TX_RAMPUP, ST_TX_START,
                                  ST_TX_ACTIVE, ST_TX_RAMPDN});
  assign nxt_rx_en = (nxt inside {ST_RX_EN, ST_RX_ACTIVE});

  // Outputs are registered decodes of the next state, so they line up with state.
  always_ff @(posedge converter_clock_in) begin
    if (!sys_rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      band_q      <= 1'b0;
      tgt_q       <= '0;
      ctl_TxEn    <= 1'b0;
      ctl_RxEn    <= 1'b0;
      ctl_RxHP    <= 1'b0;
      ctl_24PA    <= 1'b0;
      ctl_5PA     <= 1'b0;
      ctl_ANTSW   <= ANTSW_OFF;
      ctl_TxStart <= 1'b0;
      busy        <= 1'b0;
      tx_active   <= 1'b0;
      rx_active   <= 1'b0;
    end else begin
      state <= nxt;
      if (cnt_load)         cnt <= cnt_val;
      else if (cnt != '0)   cnt <= cnt - DLY_W'(1);
      if (state == ST_IDLE && nxt != ST_IDLE) begin
        band_q <= band_5ghz;
        tgt_q  <= tx_gain_target;
      end
      ctl_TxEn    <= nxt_tx_en;
      ctl_RxEn    <= nxt_rx_en;
      ctl_RxHP    <= (nxt == ST_RX_EN);
      ctl_5PA     <= nxt_pa & band_q;
      ctl_24PA    <= nxt_pa & ~band_q;
      ctl_ANTSW   <= nxt_tx_en ? ANTSW_TX : (nxt_rx_en ? ANTSW_RX : ANTSW_OFF);
      ctl_TxStart <= (nxt == ST_TX_START);
      busy        <= (nxt != ST_IDLE);
      tx_active   <= (nxt == ST_TX_ACTIVE);
      rx_active   <= (nxt == ST_RX_ACTIVE);
    end
  end

  radio_seq_gain_ramp #(
    .GAIN_W (GAIN_W),
    .DLY_W  (DLY_W)
  ) u_ramp (
    .clk       (converter_clock_in),
    .rst_n     (sys_rst_n),
    .start_up  (start_up),
    .start_dn  (start_dn),
    .target    (tgt_q),
    .step      (gain_step),
    .dly_step  (dly_gain_step),
    .gain      (ctl_Tx_gain),
    .at_target (at_target),
    .at_zero   (at_zero)
  );

endmodule

// File: tb/tb_radio_txrx_sequencer.sv
// Directed bench for radio_txrx_sequencer; gain changes are checked against a
// scoreboard of (value, cycle) entries queued when each stimulus step is driven.
module tb_radio_txrx_sequencer;

  localparam int DLY_W  = 16;
  localparam int GAIN_W = 6;

  logic              clk = 1'b0;
  logic              sys_rst_n;
  logic              tx_req, rx_req, band_5ghz;
  logic [GAIN_W-1:0] tx_gain_target, gain_step;
  logic [DLY_W-1:0]  dly_txen_to_pa, dly_pa_to_ramp, dly_gain_step, dly_rxhp;
  logic              ctl_TxEn, ctl_RxEn, ctl_RxHP, ctl_24PA, ctl_5PA;
  logic [1:0]        ctl_ANTSW;
  logic [GAIN_W-1:0] ctl_Tx_gain;
  logic              ctl_TxStart, busy, tx_active, rx_active;
`ifdef RADIO_SEQ_TX_TIMEOUT_EN
  logic [31:0]       tx_timeout_cycles;
  logic              tx_timeout;
`endif

  always #5 clk = ~clk;

  radio_txrx_sequencer #(.DLY_W(DLY_W), .GAIN_W(GAIN_W)) dut (
    .converter_clock_in (clk),
    .sys_rst_n          (sys_rst_n),
    .tx_req             (tx_req),
    .rx_req             (rx_req),
    .band_5ghz          (band_5ghz),
    .tx_gain_target     (tx_gain_target),
    .gain_step          (gain_step),
    .dly_txen_to_pa     (dly_txen_to_pa),
    .dly_pa_to_ramp     (dly_pa_to_ramp),
    .dly_gain_step      (dly_gain_step),
    .dly_rxhp           (dly_rxhp),
`ifdef RADIO_SEQ_TX_TIMEOUT_EN
    .tx_timeout_cycles  (tx_timeout_cycles),
    .tx_timeout         (tx_timeout),
`endif
    .ctl_TxEn           (ctl_TxEn),
    .ctl_RxEn           (ctl_RxEn),
    .ctl_RxHP           (ctl_RxHP),
    .ctl_24PA           (ctl_24PA),
    .ctl_5PA            (ctl_5PA),
    .ctl_ANTSW          (ctl_ANTSW),
    .ctl_Tx_gain        (ctl_Tx_gain),
    .ctl_TxStart        (ctl_TxStart),
    .busy               (busy),
    .tx_active          (tx_active),
    .rx_active          (rx_active)
  );

  typedef struct { int gain; int at; } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int txstart_cnt = 0;
  int exp_starts = 0;
  bit mon_en = 1'b0;
  logic [GAIN_W-1:0] last_gain = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (ctl_TxStart) txstart_cnt++;
      chk("txen_rxen_exclusive", 32'(ctl_TxEn & ctl_RxEn), 0);
      chk("pa_requires_txen", 32'((ctl_5PA | ctl_24PA) & ~ctl_TxEn), 0);
      if (ctl_Tx_gain !== last_gain) begin
        if (sb.size() == 0) begin
          chk("gain_unexpected_change", 32'(ctl_Tx_gain), 32'(last_gain));
        end else begin
          e = sb.pop_front();
          chk("gain_value", 32'(ctl_Tx_gain), e.gain);
          chk("gain_change_cycle", cyc, e.at);
        end
        last_gain = ctl_Tx_gain;
      end
    end
  end

  initial begin
    int c, d;
    sys_rst_n = 1'b0; tx_req = 1'b0; rx_req = 1'b0; band_5ghz = 1'b0;
    tx_gain_target = '0; gain_step = '0;
    dly_txen_to_pa = '0; dly_pa_to_ramp = '0; dly_gain_step = '0; dly_rxhp = '0;
`ifdef RADIO_SEQ_TX_TIMEOUT_EN
    tx_timeout_cycles = 32'd20;
`endif
    repeat (2) @(negedge clk);
    chk("rst_txen", 32'(ctl_TxEn), 0);
    chk("rst_rxen", 32'(ctl_RxEn), 0);
    chk("rst_pa", 32'({ctl_5PA, ctl_24PA}), 0);
    chk("rst_antsw", 32'(ctl_ANTSW), 0);
    chk("rst_gain", 32'(ctl_Tx_gain), 0);
    chk("rst_busy", 32'({busy, tx_active, rx_active, ctl_TxStart, ctl_RxHP}), 0);
    sys_rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Tx ramp-up timing on the 5 GHz PA
    dly_txen_to_pa = 16'd4; dly_pa_to_ramp = 16'd3; dly_gain_step = 16'd2;
    tx_gain_target = 6'd10; gain_step = 6'd4; band_5ghz = 1'b1;
    c = cyc; tx_req = 1'b1; exp_starts++;
    sb.push_back('{4, c + 10}); sb.push_back('{8, c + 12}); sb.push_back('{10, c + 14});
    @(negedge clk);
    chk("tx1_txen", 32'(ctl_TxEn), 1);
    chk("tx1_antsw", 32'(ctl_ANTSW), 2);
    chk("tx1_pa_early", 32'(ctl_5PA), 0);
    repeat (3) @(negedge clk);
    chk("tx1_pa_before_delay", 32'(ctl_5PA), 0);
    @(negedge clk);
    chk("tx1_5pa_on", 32'(ctl_5PA), 1);
    chk("tx1_24pa_off", 32'(ctl_24PA), 0);
    repeat (10) @(negedge clk);
    chk("tx1_txstart", 32'(ctl_TxStart), 1);
    chk("tx1_not_active_yet", 32'(tx_active), 0);
    @(negedge clk);
    chk("tx1_txstart_single", 32'(ctl_TxStart), 0);
    chk("tx1_active", 32'(tx_active), 1);
    chk("tx1_gain_hold", 32'(ctl_Tx_gain), 10);
    repeat (4) @(negedge clk);

    // Ramp-down after tx_req drops
    d = cyc; tx_req = 1'b0;
    sb.push_back('{6, d + 3}); sb.push_back('{2, d + 5}); sb.push_back('{0, d + 7});
    repeat (7) @(negedge clk);
    chk("dn_pa_still_on", 32'(ctl_5PA), 1);
    @(negedge clk);
    chk("dn_pa_off", 32'(ctl_5PA), 0);
    chk("dn_txen_held", 32'(ctl_TxEn), 1);
    repeat (3) @(negedge clk);
    chk("dn_txen_still", 32'(ctl_TxEn), 1);
    @(negedge clk);
    chk("dn_txen_off", 32'(ctl_TxEn), 0);
    chk("dn_idle", 32'(busy), 0);
    chk("dn_antsw_off", 32'(ctl_ANTSW), 0);
    chk("dn_one_txstart", txstart_cnt, 1);
    chk("dn_sb_drained", sb.size(), 0);

    // Rx with RxHP hold of 5
    dly_rxhp = 16'd5; rx_req = 1'b1;
    @(negedge clk);
    chk("rx_en", 32'({ctl_RxEn, ctl_RxHP, ctl_TxEn}), 32'b110);
    chk("rx_antsw", 32'(ctl_ANTSW), 1);
    repeat (4) @(negedge clk);
    chk("rx_hp_last", 32'(ctl_RxHP), 1);
    @(negedge clk);
    chk("rx_hp_off", 32'(ctl_RxHP), 0);
    chk("rx_active", 32'({ctl_RxEn, rx_active}), 32'b11);
    chk("rx_antsw_hold", 32'(ctl_ANTSW), 1);
    repeat (3) @(negedge clk);
    rx_req = 1'b0;
    @(negedge clk);
    chk("rx_exit", 32'({ctl_RxEn, busy, rx_active, ctl_ANTSW}), 0);

    // Simultaneous requests: Tx wins, Rx follows after an IDLE cycle
    dly_txen_to_pa = 16'd1; dly_pa_to_ramp = 16'd1; dly_gain_step = 16'd1; dly_rxhp = 16'd1;
    tx_gain_target = 6'd5; gain_step = 6'd5; band_5ghz = 1'b0;
    c = cyc; tx_req = 1'b1; rx_req = 1'b1; exp_starts++;
    sb.push_back('{5, c + 4});
    @(negedge clk);
    chk("both_txen", 32'({ctl_TxEn, ctl_RxEn}), 32'b10);
    repeat (3) @(negedge clk);
    chk("both_24pa", 32'({ctl_24PA, ctl_5PA}), 32'b10);
    repeat (4) @(negedge clk);
    d = cyc; tx_req = 1'b0;
    sb.push_back('{0, d + 2});
    repeat (4) @(negedge clk);
    chk("both_idle_gap", 32'({busy, ctl_TxEn, ctl_RxEn}), 0);
    @(negedge clk);
    chk("both_rx_after", 32'({ctl_RxEn, busy}), 32'b11);
    rx_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("both_rx_done", 32'(busy), 0);

    // Reset mid ramp-up at gain 8
    dly_txen_to_pa = 16'd4; dly_pa_to_ramp = 16'd3; dly_gain_step = 16'd2;
    tx_gain_target = 6'd10; gain_step = 6'd4; band_5ghz = 1'b1;
    c = cyc; tx_req = 1'b1;
    sb.push_back('{4, c + 10}); sb.push_back('{8, c + 12}); sb.push_back('{0, c + 13});
    repeat (12) @(negedge clk);
    chk("rst_mid_gain8", 32'(ctl_Tx_gain), 8);
    sys_rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_outputs", 32'({ctl_TxEn, ctl_5PA, ctl_24PA, ctl_ANTSW, busy, tx_active}), 0);
    chk("rst_mid_gain", 32'(ctl_Tx_gain), 0);
    tx_req = 1'b0; sys_rst_n = 1'b1;
    @(negedge clk);

    // Zero delays and zero gain step behave as 1
    dly_txen_to_pa = '0; dly_pa_to_ramp = '0; dly_gain_step = '0; dly_rxhp = '0;
    tx_gain_target = 6'd3; gain_step = '0; band_5ghz = 1'b0;
    c = cyc; tx_req = 1'b1; exp_starts++;
    sb.push_back('{1, c + 4}); sb.push_back('{2, c + 5}); sb.push_back('{3, c + 6});
    @(negedge clk);
    chk("z_txen", 32'({ctl_TxEn, ctl_24PA}), 32'b10);
    @(negedge clk);
    chk("z_24pa", 32'(ctl_24PA), 1);
    repeat (5) @(negedge clk);
    chk("z_txstart", 32'(ctl_TxStart), 1);
    repeat (2) @(negedge clk);
    d = cyc; tx_req = 1'b0;
    sb.push_back('{2, d + 2}); sb.push_back('{1, d + 3}); sb.push_back('{0, d + 4});
    repeat (5) @(negedge clk);
    chk("z_pa_off", 32'({ctl_24PA, ctl_TxEn}), 32'b01);
    @(negedge clk);
    chk("z_idle", 32'({ctl_TxEn, busy}), 0);
    rx_req = 1'b1;
    @(negedge clk);
    chk("z_rxhp", 32'({ctl_RxEn, ctl_RxHP}), 32'b11);
    @(negedge clk);
    chk("z_rxhp_off", 32'({ctl_RxEn, ctl_RxHP}), 32'b10);
    rx_req = 1'b0;
    @(negedge clk);
    chk("z_rx_done", 32'(busy), 0);

`ifdef RADIO_SEQ_TX_TIMEOUT_EN
    // Watchdog forces ramp-down after 20 TX_ACTIVE cycles
    tx_gain_target = 6'd5; gain_step = 6'd5; tx_timeout_cycles = 32'd20;
    c = cyc; tx_req = 1'b1; exp_starts++;
    sb.push_back('{5, c + 4}); sb.push_back('{0, c + 27});
    repeat (25) @(negedge clk);
    chk("to_active_last", 32'({tx_active, tx_timeout}), 32'b10);
    @(negedge clk);
    chk("to_fired", 32'({tx_active, tx_timeout}), 32'b01);
    repeat (7) @(negedge clk);
    chk("to_no_reentry", 32'({busy, tx_timeout}), 32'b01);
    tx_req = 1'b0;
    @(negedge clk);
    tx_req = 1'b1;
    @(negedge clk);
    chk("to_reentry", 32'({ctl_TxEn, tx_timeout}), 32'b10);
    sys_rst_n = 1'b0; tx_req = 1'b0;
    @(negedge clk);
    sys_rst_n = 1'b1;
    @(negedge clk);
`endif

    chk("txstart_total", txstart_cnt, exp_starts);
    chk("sb_empty_end", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
